wave_trig_capture: RTL and testbench
====================================

# wave_trig_capture

Triggered waveform capture buffer for the oscilloscope path. Sits on the AD clock alongside the parameter-measurement stage, consuming the same raw `ad_data` stream and `trig_level`, and stores one frame of decimated samples around a level-crossing trigger. The frame is held in an internal circular RAM and read out by the display/waveform-drawing logic through a simple address/data port with a frame-ready/done handshake.

## Interface

Parameters:
- `WIDTH`, 12: AD sample width.
- `AW`, 10: buffer address width; depth `DEPTH = 2**AW` (1024).
- `PRE_TRIG`, 128: samples kept before the trigger point; must be `< DEPTH`.
- `AUTO_TIMEOUT`, 24'd6_500_000: AD-clock cycles in WAIT_TRIG before a forced trigger (about 0.1 s at 65 MHz).

Ports:
- `ad_clk`, in, 1: AD clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `ad_data`, in, WIDTH: raw AD sample, valid every cycle.
- `trig_level`, in, WIDTH: trigger threshold.
- `trig_fall`, in, 1: 0 selects a rising-edge trigger; 1 selects a falling-edge trigger.
- `auto_en`, in, 1: enables the forced trigger on timeout.
- `decim`, in, 8: the block stores one sample every `decim+1` cycles.
- `arm`, in, 1: one-cycle pulse that starts a capture.
- `frame_ready`, out, 1: a frame is complete and readable.
- `trig_forced`, out, 1: the last frame was triggered by timeout.
- `busy`, out, 1: the state is PRE, WAIT_TRIG or POST.
- `rd_addr`, in, AW: frame-relative read index. Index 0 is the oldest sample. Index `PRE_TRIG` is the trigger sample.
- `rd_data`, out, WIDTH: sample at `rd_addr`; registered.
- `rd_done`, in, 1: one-cycle pulse from the reader that releases the frame.

## Operation

- **Sample strobe `s_en`**
  - Driven by a decimation counter that counts 0..`decim`.
  - `s_en` is 1 when the counter is 0.
  - The counter is cleared on `arm` accepted.
- **Write side**
  - On `s_en`, the block writes `ad_data` at `wr_ptr` and increments `wr_ptr` (wraps modulo DEPTH).
  - The block writes only in PRE, WAIT_TRIG and POST.
- **Trigger detection**
  - Evaluated on `s_en` only, using `prev` (the last stored sample) and `cur` (`ad_data`).
  - Rising trigger: `prev < trig_level && cur >= trig_level`.
  - Falling trigger: `prev > trig_level && cur <= trig_level`.
  - Comparisons are unsigned WIDTH-bit.
- **FSM**
  - IDLE: `arm` → PRE. Load `wr_ptr=0` and `fill_cnt=0`, clear `trig_forced`, reset `to_cnt`.
  - PRE: count stored samples. Once `fill_cnt == PRE_TRIG`, go to WAIT_TRIG. Triggers are ignored in PRE.
  - WAIT_TRIG: on a trigger, latch `trig_ptr = wr_ptr` (the address of `cur`), load `post_cnt = DEPTH-PRE_TRIG-1`, and go to POST.
    - `to_cnt` increments every cycle.
    - If `auto_en` is 1 and `to_cnt == AUTO_TIMEOUT-1`, the block forces a trigger on the next `s_en` and sets `trig_forced`.
  - POST: decrement `post_cnt` on each `s_en`. The sample written when `post_cnt == 0` is the last; go to READY. The frame then holds exactly DEPTH samples.
  - READY: `frame_ready=1`. `rd_done` → IDLE. `arm` → PRE (re-arm, frame discarded). If both arrive in the same cycle, `arm` wins.
- **Read side**
  - Physical address = `(trig_ptr - PRE_TRIG + rd_addr) mod DEPTH`, in AW-bit wrap arithmetic.
  - `rd_data` is valid one cycle after `rd_addr`.
  - Reads in states other than READY return RAM contents with no guarantee.
- **`arm` handling**
  - `arm` in PRE, WAIT_TRIG or POST is ignored.
  - `arm` is not queued.

## Timing

- **Reset values:** state IDLE, `frame_ready=0`, `trig_forced=0`, `busy=0`, `rd_data=0`, and all pointers and counters 0. Reset mid-capture abandons the frame. RAM contents are not cleared.
- **Arm latency:** `busy` rises in the cycle after `arm`. The first write occurs in that same cycle (decimation counter = 0).
- **Minimum capture length,** with `decim=0` and the trigger present at the end of PRE: `PRE_TRIG` + 1 + (`DEPTH-PRE_TRIG-1`) = DEPTH write cycles. `frame_ready` rises the cycle after the last write.
- **Forced trigger:** occurs no earlier than `AUTO_TIMEOUT` cycles after entering WAIT_TRIG.
- **Changing inputs:** `trig_level` and `trig_fall` may change at any time and take effect on the next `s_en`. `decim` is sampled continuously; changing it mid-capture is legal but distorts the time base.
- **Single-cycle flags:** `frame_ready` and `busy` are never both 1.

## Structure

- **Shared package `osc_pkg`:** the state enum (IDLE, PRE, WAIT_TRIG, POST, READY), the `WIDTH` default and the trigger-edge encoding constants.
- **Sub-module `wave_ram_dp`:** simple dual-port RAM, DEPTH×WIDTH, one write port and one registered read port, same clock. It must infer block RAM.
- **Top level:** FSM, decimator, trigger detector, timeout counter and read-address translation.

## Test plan

- **Ramp capture:** `decim=0`, rising trigger at level 2048, and an incrementing ramp in which `ad_data` passes 2048 at a known cycle. Required response:
  - `rd_addr=PRE_TRIG` reads 2048.
  - `rd_addr=0` reads 2048-128.
  - `rd_addr=1023` reads 2048+895.
  - `trig_forced=0`.
- **Falling edge:** `trig_fall=1` with a descending ramp. The trigger sample must be the first value ≤ level; `prev` must be > level.
- **No crossing:** constant `ad_data=100`, `auto_en=1`. `frame_ready` must rise after about `AUTO_TIMEOUT` + DEPTH-PRE_TRIG cycles with `trig_forced=1`. With `auto_en=0`, the block must stay in WAIT_TRIG indefinitely.
- **Decimation with wrap:** `decim=3`. Stored samples must be every 4th ramp value. Run with `PRE_TRIG` and a trigger that forces a wrap of the physical address; the frame-relative read order must stay monotonic.
- **Handshake:**
  - `arm` during POST is ignored.
  - `rd_done` in READY → IDLE with `frame_ready=0` the next cycle.
  - `arm` and `rd_done` together in READY → a new capture starts (`busy=1`).
- **Reset:** assert `rst` for one cycle mid-POST. Next cycle: state IDLE, all outputs at reset values, and a subsequent `arm` captures a correct frame.

Source files
------------

// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared types and constants for the oscilloscope capture path
package osc_pkg;

  localparam int OSC_WIDTH = 12;

  // Trigger-edge encoding for the trig_fall input
  localparam logic TRIG_RISE = 1'b0;
  localparam logic TRIG_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    READY
  } state_t;

endpackage

// File: rtl/wave_ram_dp.sv
// rtl/wave_ram_dp.sv - simple dual-port frame RAM with registered read
module wave_ram_dp #(
  parameter int WIDTH = 12,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read port; only the output register is reset
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/wave_trig_capture.sv
// rtl/wave_trig_capture.sv - level-triggered decimated waveform capture buffer
module wave_trig_capture
  import osc_pkg::*;
#(
  parameter int          WIDTH        = OSC_WIDTH,
  parameter int          AW           = 10,
  parameter int          PRE_TRIG     = 128,
  parameter logic [23:0] AUTO_TIMEOUT = 24'd6_500_000
) (
  input  logic             ad_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ad_data,
  input  logic [WIDTH-1:0] trig_level,
  input  logic             trig_fall,
  input  logic             auto_en,
  input  logic [7:0]       decim,
  input  logic             arm,
  output logic             frame_ready,
  output logic             trig_forced,
  output logic             busy,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_done
);

  localparam int              DEPTH     = 1 << AW;
  localparam logic [AW-1:0]   PRE_LAST  = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0]   PRE_OFS   = AW'(PRE_TRIG);
  // Post-trigger writes so that pre + trigger + post fills the ring exactly once
  localparam logic [AW-1:0]   POST_LOAD = AW'(DEPTH - PRE_TRIG - 1);

  state_t           state, state_nxt;
  logic [7:0]       dcnt;
  logic [AW-1:0]    wr_ptr, trig_ptr, fill_cnt, post_cnt, phys_rd;
  logic [23:0]      to_cnt;
  logic [WIDTH-1:0] prev;
  logic             force_pend, forced_r;
  logic             s_en, arm_ok, wr_en, edge_hit, force_now, trig_take;

  assign s_en      = (dcnt == 8'd0);
  assign arm_ok    = arm && (state == IDLE || state == READY);
  assign wr_en     = s_en && (state == PRE || state == WAIT_TRIG || state == POST);
  assign edge_hit  = (trig_fall == TRIG_FALL) ? (prev > trig_level && ad_data <= trig_level)
                                              : (prev < trig_level && ad_data >= trig_level);
  assign force_now = force_pend && auto_en;
  assign trig_take = s_en && (state == WAIT_TRIG) && (edge_hit || force_now);
  // Frame index 0 is PRE_TRIG samples before the trigger, wrapping in AW bits
  assign phys_rd   = trig_ptr - PRE_OFS + rd_addr;
  assign trig_forced = forced_r;

  // Decimation counter; restarting at 0 on arm makes the first write immediate
  always_ff @(posedge ad_clk) begin
    if (rst)               dcnt <= 8'd0;
    else if (arm_ok)       dcnt <= 8'd0;
    else if (dcnt >= decim) dcnt <= 8'd0;
    else                   dcnt <= dcnt + 8'd1;
  end

  // State register
  always_ff @(posedge ad_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status flags
  always_comb begin
    state_nxt   = state;
    frame_ready = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_nxt = PRE;
      end
      PRE: begin
        busy = 1'b1;
        if (s_en && fill_cnt == PRE_LAST) state_nxt = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        busy = 1'b1;
        if (trig_take) state_nxt = (POST_LOAD == '0) ? READY : POST;
      end
      POST: begin
        busy = 1'b1;
        if (s_en && post_cnt == AW'(1)) state_nxt = READY;
      end
      READY: begin
        frame_ready = 1'b1;
        if (arm)          state_nxt = PRE;
        else if (rd_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write pointer, fill/post/timeout counters and trigger bookkeeping
  always_ff @(posedge ad_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      trig_ptr   <= '0;
      to_cnt     <= '0;
      prev       <= '0;
      force_pend <= 1'b0;
      forced_r   <= 1'b0;
    end else if (arm_ok) begin
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      to_cnt     <= '0;
      force_pend <= 1'b0;
      forced_r   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        prev   <= ad_data;
      end
      if (state == PRE && s_en) fill_cnt <= fill_cnt + AW'(1);
      if (state == WAIT_TRIG) begin
        to_cnt <= to_cnt + 24'd1;
        if (auto_en && to_cnt == AUTO_TIMEOUT - 24'd1) force_pend <= 1'b1;
      end
      if (state == POST && s_en) post_cnt <= post_cnt - AW'(1);
      // A genuine edge in the same sample takes precedence over the timeout
      if (trig_take) begin
        trig_ptr   <= wr_ptr;
        post_cnt   <= POST_LOAD;
        force_pend <= 1'b0;
        if (!edge_hit) forced_r <= 1'b1;
      end
    end
  end

  wave_ram_dp #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (ad_clk),
    .rst     (rst),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (ad_data),
    .rd_addr (phys_rd),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_wave_trig_capture.sv
// tb/tb_wave_trig_capture.sv - scoreboard bench for wave_trig_capture
module tb_wave_trig_capture;

  localparam int WIDTH = 12;
  localparam int AW    = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] ad_data;
  logic [WIDTH-1:0] trig_level;
  logic             trig_fall;
  logic             auto_en;
  logic [7:0]       decim;
  logic             arm;
  logic             frame_ready;
  logic             trig_forced;
  logic             busy;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_done;

  wave_trig_capture #(
    .WIDTH(WIDTH), .AW(AW), .PRE_TRIG(128), .AUTO_TIMEOUT(24'd300)
  ) dut (
    .ad_clk(clk), .rst(rst), .ad_data(ad_data), .trig_level(trig_level),
    .trig_fall(trig_fall), .auto_en(auto_en), .decim(decim), .arm(arm),
    .frame_ready(frame_ready), .trig_forced(trig_forced), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int t_cyc  = 0;
  logic rd_req = 1'b0, rd_vld = 1'b0, stat_req = 1'b0;

  string            rname_q[$];
  logic [WIDTH-1:0] rexp_q[$];
  string            sname_q[$];
  logic [2:0]       sexp_q[$];

  function automatic logic [WIDTH-1:0] gen(input int m, input int t);
    case (m)
      0: return 12'(1500 + t);
      1: return 12'(3000 - t);
      2: return 12'd100;
      3: return 12'd3000;
      4: return (t < 2000) ? 12'd0 : 12'(t - 2000);
      5: return (t < 128) ? 12'd0 : 12'(2048 + t - 128);
      default: return 12'd0;
    endcase
  endfunction

  // Read data appears one cycle after the request
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      checks++;
      if (rexp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %0d expected none", rd_data);
      end else begin
        string n;
        logic [WIDTH-1:0] e;
        n = rname_q.pop_front();
        e = rexp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", n, rd_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (stat_req) begin
      string n;
      logic [2:0] e;
      checks++;
      n = sname_q.pop_front();
      e = sexp_q.pop_front();
      if ({frame_ready, busy, trig_forced} !== e) begin
        errors++;
        $display("FAIL %s: got fr/busy/tf=%b expected %b", n, {frame_ready, busy, trig_forced}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    arm      = 1'b0;
    rd_done  = 1'b0;
    rd_req   = 1'b0;
    stat_req = 1'b0;
    ad_data  = gen(mode, t_cyc);
    t_cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_stat(input string name, input logic [2:0] exp);
    sname_q.push_back(name);
    sexp_q.push_back(exp);
    stat_req = 1'b1;
  endtask

  task automatic rd(input string name, input int addr, input int exp);
    rd_addr = AW'(addr);
    rname_q.push_back(name);
    rexp_q.push_back(WIDTH'(exp));
    rd_req = 1'b1;
    tick();
  endtask

  task automatic start(input int m);
    mode  = m;
    t_cyc = 0;
    arm   = 1'b1;
    tick();
    chk_stat("busy_after_arm", 3'b010);
  endtask

  task automatic wait_ready(input string name, input int budget, input int arm_at, input int exp_cyc);
    int n = 0;
    while (!frame_ready && n < budget) begin
      tick();
      n++;
      if (arm_at >= 0 && t_cyc - 1 == arm_at) arm = 1'b1;
    end
    if (!frame_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: got no frame_ready expected one within %0d cycles", name, budget);
    end else begin
      chk(name, t_cyc - 1, exp_cyc);
    end
  endtask

  task automatic release_frame(input string name, input logic tf);
    rd_done = 1'b1;
    tick();
    chk_stat(name, {2'b00, tf});
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ad_data = '0; trig_level = 12'd2048; trig_fall = 1'b0;
    auto_en = 1'b0; decim = 8'd0; arm = 1'b0; rd_addr = '0; rd_done = 1'b0;
    tick(); tick();
    chk_stat("reset_flags", 3'b000);
    rd("reset_rd_data", 5, 0);
    rst = 1'b0;
    tick();

    // Rising ramp crossing 2048 well after the pre-trigger fill
    start(0);
    wait_ready("ramp_ready_cycle", 3000, -1, 1444);
    chk_stat("ramp_flags", 3'b100);
    rd("ramp_idx0", 0, 1920);
    rd("ramp_idx127", 127, 2047);
    rd("ramp_trig", 128, 2048);
    rd("ramp_idx1023", 1023, 2943);
    release_frame("ramp_rd_done", 1'b0);

    // Falling ramp; an arm pulse mid-POST must not restart the capture
    trig_fall = 1'b1; trig_level = 12'd2000;
    start(1);
    wait_ready("fall_ready_cycle", 3000, 1500, 1896);
    rd("fall_idx0", 0, 2128);
    rd("fall_prev", 127, 2001);
    rd("fall_trig", 128, 2000);
    rd("fall_idx1023", 1023, 1105);
    release_frame("fall_rd_done", 1'b0);

    // No crossing with auto trigger
    trig_fall = 1'b0; trig_level = 12'd2048; auto_en = 1'b1;
    start(2);
    wait_ready("auto_ready_cycle", 3000, -1, 1324);
    chk_stat("auto_flags", 3'b101);
    rd("auto_trig", 128, 100);
    release_frame("auto_rd_done", 1'b1);

    // No crossing without auto trigger stays waiting; then reset mid-POST
    auto_en = 1'b0;
    start(2);
    repeat (2000) tick();
    chk_stat("stuck_waiting", 3'b010);
    mode = 3;
    repeat (300) tick();
    chk_stat("in_post", 3'b010);
    rst = 1'b1;
    rd("rst_rd_data", 0, 0);
    rst = 1'b0;
    chk_stat("after_reset", 3'b000);
    tick();

    // Decimation by 4 with a physical wrap inside the frame
    decim = 8'd3; trig_level = 12'd4;
    start(4);
    wait_ready("decim_ready_cycle", 8000, -1, 5585);
    rd("decim_idx0", 0, 0);
    rd("decim_trig", 128, 4);
    rd("decim_idx200", 200, 292);
    rd("decim_idx651", 651, 2096);
    rd("decim_idx652", 652, 2100);
    rd("decim_idx1023", 1023, 3584);

    // arm and rd_done together in READY: arm wins; minimum-length capture
    decim = 8'd0; trig_level = 12'd2048;
    rd_done = 1'b1;
    start(5);
    wait_ready("min_ready_cycle", 3000, -1, 1024);
    chk_stat("min_flags", 3'b100);
    rd("min_idx127", 127, 0);
    rd("min_trig", 128, 2048);
    rd("min_idx1023", 1023, 2943);
    tick(); tick();
    chk("read_queue_drained", rexp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
